// File: rtl/sipo_rx.sv
// sipo_rx: LSB-first serial-in parallel-out receiver.
// Collects framed serial bits into a shift register and hands each completed
// word to a downstream consumer through a valid/ready holding register.
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   sin, en       serial bit and its qualifier
//   start         frame start, marks bit 0 of a word (only with en)
//   dout          holding register (received word)
//   dout_valid    dout holds an unconsumed word
//   dout_ready    consumer accepts dout this cycle
//   busy          frame in progress
//   bit_cnt       bits received in the current frame
//   overrun       sticky: completed word dropped, holding register full
//   clr_ovr       synchronous clear of overrun
module sipo_rx #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             en,
    input  logic             start,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic [CW-1:0]    bit_cnt,
    output logic             overrun,
    input  logic             clr_ovr
);

    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q,      state_d;
    logic [WIDTH-1:0] sreg_q,       sreg_d;
    logic [CW-1:0]    bit_cnt_q,    bit_cnt_d;
    logic [WIDTH-1:0] dout_q,       dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             busy_q,       busy_d;
    logic             overrun_q,    overrun_d;

    logic [WIDTH-1:0] shifted;
    logic             complete;
    logic             ovr_set;

    // Frame FSM, shift register and holding-register next-state logic.
    always_comb begin
        state_d      = state_q;
        sreg_d       = sreg_q;
        bit_cnt_d    = bit_cnt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        complete     = 1'b0;
        ovr_set      = 1'b0;
        shifted      = {sin, sreg_q[WIDTH-1:1]};

        // sin is only looked at under en, so an unknown sin in gaps stays out.
        case (state_q)
            IDLE: begin
                if (en && start) begin
                    sreg_d    = shifted;
                    bit_cnt_d = CW'(1);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (en) begin
                    sreg_d = shifted;
                    if (start) begin
                        // Abort the partial frame; this bit is the new bit 0.
                        bit_cnt_d = CW'(1);
                    end else if (bit_cnt_q == LAST_CNT) begin
                        complete  = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
            end
        endcase

        // Holding register: refill when empty or consumed in the same cycle.
        if (complete) begin
            if (!dout_valid_q || dout_ready) begin
                dout_d       = shifted;
                dout_valid_d = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        // Set beats clear when both happen together.
        overrun_d = ovr_set | (overrun_q & ~clr_ovr);
        busy_d    = (state_d == SHIFT);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sreg_q       <= '0;
            bit_cnt_q    <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            bit_cnt_q    <= bit_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;
    assign bit_cnt    = bit_cnt_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_sipo_rx.sv
// Testbench for sipo_rx: scenario tasks with inline checks plus a scoreboard
// of expected words popped whenever the consumer handshake completes.
module tb_sipo_rx;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CW    = 3;

    logic             clk;
    logic             rst;
    logic             sin;
    logic             en;
    logic             start;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic [CW-1:0]    bit_cnt;
    logic             overrun;
    logic             clr_ovr;

    int n_checks = 0;
    int n_fail   = 0;
    logic [WIDTH-1:0] exp_q[$];

    sipo_rx #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .en         (en),
        .start      (start),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .bit_cnt    (bit_cnt),
        .overrun    (overrun),
        .clr_ovr    (clr_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every handshake must deliver the oldest expected word.
    always @(negedge clk) begin
        if (!rst && dout_valid === 1'b1 && dout_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got %h, expected no word", dout);
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                if (dout !== e) begin
                    n_fail++;
                    $display("FAIL sb_word: got %h, expected %h", dout, e);
                end
            end
        end
    end

    // Apply one cycle of serial inputs; returns 1 time unit after the edge.
    task automatic drive(input logic b, input logic e, input logic s);
        sin   = b;
        en    = e;
        start = s;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'bx, 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w);
        for (int i = 0; i < WIDTH; i++) drive(w[i], 1'b1, (i == 0));
    endtask

    task automatic test_reset;
        rst = 1'b1; sin = 1'b0; en = 1'b0; start = 1'b0;
        dout_ready = 1'b0; clr_ovr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({dout, dout_valid, busy, bit_cnt, overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got dout=%h v=%b busy=%b cnt=%0d ovr=%b, expected all 0",
                     dout, dout_valid, busy, bit_cnt, overrun);
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_basic;
        logic [WIDTH-1:0] w;
        logic [CW-1:0]    exp_cnt [WIDTH] = '{CW'(1), CW'(2), CW'(3), CW'(0)};
        logic             exp_busy[WIDTH] = '{1'b1, 1'b1, 1'b1, 1'b0};
        w = 4'hB;
        dout_ready = 1'b1;
        exp_q.push_back(4'hB);
        for (int i = 0; i < WIDTH; i++) begin
            drive(w[i], 1'b1, (i == 0));
            n_checks++;
            if (bit_cnt !== exp_cnt[i] || busy !== exp_busy[i]) begin
                n_fail++;
                $display("FAIL basic_cnt[%0d]: got cnt=%0d busy=%b, expected cnt=%0d busy=%b",
                         i, bit_cnt, busy, exp_cnt[i], exp_busy[i]);
            end
        end
        n_checks++;
        if (dout_valid !== 1'b1 || dout !== 4'hB) begin
            n_fail++;
            $display("FAIL basic_latency: got v=%b dout=%h, expected v=1 dout=b", dout_valid, dout);
        end
        idle(1);
        n_checks++;
        if (dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pulse: got v=%b, expected 0", dout_valid);
        end
        idle(1);
    endtask

    task automatic test_gap;
        dout_ready = 1'b1;
        exp_q.push_back(4'hB);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive(1'bx, 1'b0, 1'b0);
            n_checks++;
            if (bit_cnt !== CW'(2) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL gap_hold[%0d]: got cnt=%0d busy=%b, expected cnt=2 busy=1",
                         i, bit_cnt, busy);
            end
        end
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (dout !== 4'hB || dout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL gap_word: got dout=%h v=%b, expected b v=1", dout, dout_valid);
        end
        idle(2);
    endtask

    task automatic test_overrun;
        dout_ready = 1'b0;
        exp_q.push_back(4'h5);
        send_word(4'h5);
        n_checks++;
        if (overrun !== 1'b0 || dout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_first: got ovr=%b v=%b, expected ovr=0 v=1", overrun, dout_valid);
        end
        send_word(4'hA);
        n_checks++;
        if (dout !== 4'h5 || dout_valid !== 1'b1 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_drop: got dout=%h v=%b ovr=%b, expected 5 v=1 ovr=1",
                     dout, dout_valid, overrun);
        end
        idle(2);
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_sticky: got ovr=%b, expected 1", overrun);
        end
        clr_ovr = 1'b1;
        idle(1);
        clr_ovr = 1'b0;
        n_checks++;
        if (overrun !== 1'b0 || dout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_clear: got ovr=%b v=%b, expected ovr=0 v=1", overrun, dout_valid);
        end
        dout_ready = 1'b1;
        idle(1);
        dout_ready = 1'b0;
        n_checks++;
        if (dout_valid !== 1'b0 || dout !== 4'h5) begin
            n_fail++;
            $display("FAIL ovr_consume: got v=%b dout=%h, expected v=0 dout=5", dout_valid, dout);
        end
        idle(1);
    endtask

    task automatic test_back_to_back;
        logic [WIDTH-1:0] w;
        w = 4'h3;
        dout_ready = 1'b0;
        exp_q.push_back(4'hC);
        exp_q.push_back(4'h3);
        send_word(4'hC);
        for (int i = 0; i < WIDTH; i++) begin
            if (i == WIDTH - 1) dout_ready = 1'b1;
            drive(w[i], 1'b1, (i == 0));
            dout_ready = 1'b0;
            n_checks++;
            if (dout_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_valid[%0d]: got v=%b, expected 1", i, dout_valid);
            end
        end
        n_checks++;
        if (dout !== 4'h3 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_refill: got dout=%h ovr=%b, expected 3 ovr=0", dout, overrun);
        end
        dout_ready = 1'b1;
        idle(1);
        dout_ready = 1'b0;
        idle(1);
    endtask

    task automatic test_abort;
        dout_ready = 1'b1;
        exp_q.push_back(4'hC);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (bit_cnt !== CW'(1) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_restart: got cnt=%0d busy=%b, expected cnt=1 busy=1", bit_cnt, busy);
        end
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (dout !== 4'hC || dout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_word: got dout=%h v=%b, expected c v=1", dout, dout_valid);
        end
        idle(2);
    endtask

    task automatic test_async_reset;
        // This word is left pending and is discarded by the reset.
        dout_ready = 1'b0;
        send_word(4'h6);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (bit_cnt !== CW'(2) || dout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_pre: got cnt=%0d v=%b, expected cnt=2 v=1", bit_cnt, dout_valid);
        end
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({dout, dout_valid, busy, bit_cnt, overrun} !== '0) begin
            n_fail++;
            $display("FAIL arst_now: got dout=%h v=%b busy=%b cnt=%0d ovr=%b, expected all 0",
                     dout, dout_valid, busy, bit_cnt, overrun);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        dout_ready = 1'b1;
        exp_q.push_back(4'h9);
        send_word(4'h9);
        n_checks++;
        if (dout !== 4'h9 || dout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_after: got dout=%h v=%b, expected 9 v=1", dout, dout_valid);
        end
        idle(3);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_overrun();
        test_back_to_back();
        test_abort();
        test_async_reset();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d words outstanding, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sipo_rx.md
Name: sipo_rx

Overview:
Serial-in parallel-out deserializing receiver. It is the far end of the team's LSB-first serial link, whose transmitter shifts a loaded word out of bit 0 one bit per enabled cycle. The block collects framed serial bits into a shift register and hands each completed word to a downstream consumer over a valid/ready holding register. It reports overrun when the consumer falls behind.

Parameters:
WIDTH, 4, word width in bits (>= 2).
CW, 3, bit-counter width; must satisfy 2**CW > WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
sin  input  1  serial data bit, LSB of word first
en  input  1  sin is a valid bit this cycle
start  input  1  frame start; asserted with the first bit of a word (en must also be high)
dout  output  WIDTH  received word (holding register)
dout_valid  output  1  dout holds an unconsumed word
dout_ready  input  1  consumer accepts dout this cycle
busy  output  1  frame in progress (state SHIFT)
bit_cnt  output  CW  bits received in current frame
overrun  output  1  sticky: completed word dropped because holding register full
clr_ovr  input  1  synchronous clear of overrun

Behaviour:
- Reset (async, rst=1): state IDLE, shift register=0, bit_cnt=0, dout=0, dout_valid=0, busy=0, overrun=0. Applies immediately, mid-frame included; the partial word is discarded.
- Shift rule: on an accepted bit, sreg <= {sin, sreg[WIDTH-1:1]}, so the first bit received lands in dout[0] after WIDTH bits.
- IDLE:
  - start&en: accept sin as bit 0, bit_cnt<=1, go to SHIFT.
  - en without start: ignored.
  - start without en: ignored (no frame begins).
- SHIFT:
  - en&!start: accept bit, bit_cnt++.
  - en&start: abort the partial frame, restart with this bit as bit 0, bit_cnt<=1.
  - en=0: hold all state (gaps between bits are legal, unlimited length).
- Completion: the cycle in which the WIDTH-th bit is accepted produces the word {sin, sreg[WIDTH-1:1]}.
  - Next state is IDLE and bit_cnt<=0.
  - Transfer to dout occurs at that same edge, so dout_valid rises one cycle after the last bit's cycle (latency 1).
- Holding register: at completion the word is written to dout and dout_valid<=1 if either dout_valid=0, or dout_valid=1 and dout_ready=1 that cycle. The second case is a simultaneous consume and refill, and dout_valid stays 1.
  - If dout_valid=1 and dout_ready=0 at completion, the new word is dropped, dout is unchanged and overrun<=1.
- Consume: dout_valid=1&dout_ready=1 with no completion gives dout_valid<=0. dout retains its value.
  - dout_ready while dout_valid=0 has no effect.
- dout_valid is never deasserted without dout_ready. dout is stable while dout_valid=1 and not consumed.
- overrun: sticky until clr_ovr or rst. If clr_ovr coincides with a new overrun event, set wins (overrun=1).
- busy=1 exactly when state=SHIFT. bit_cnt ranges 0..WIDTH-1 as observed, and is 0 in IDLE.
- Back-to-back frames: start&en may arrive in the cycle immediately after completion, with no idle cycle required.
- X on sin while en=0 must not propagate into state.

Test Plan:
1. WIDTH=4, dout_ready=1. Bits 1,1,0,1 on 4 consecutive cycles, start with the first. Expect dout=4'hB and dout_valid=1 for 1 cycle, starting the cycle after the 4th bit; busy high for 3 cycles; bit_cnt sequence 1,2,3,0.
2. Same word with en low for 2 cycles between bits 2 and 3. Expect the same dout=4'hB, and bit_cnt holds at 2 during the gap.
3. dout_ready=0. Send 4'h5 then back-to-back 4'hA. Expect dout stays 4'h5, dout_valid stays 1, overrun=1. Then clr_ovr gives overrun=0. Then ready gives dout_valid=0.
4. dout_ready pulsed exactly in the completion cycle of word 2 (4'h3 after 4'hC). Expect dout to switch 4'hC to 4'h3 with dout_valid continuously 1 and overrun=0.
5. Send 2 bits, then start&en with bits 0,0,1,1. Expect dout=4'hC and the aborted partial bits absent.
6. Assert rst asynchronously mid-frame (bit_cnt=2) and while dout_valid=1. Expect all outputs 0 immediately; then a full frame of 4'h9 receives correctly.
